// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids
// and the byte-mask width.
package mem_arb_pkg;

    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the IFU, bit 1 the LSU.
// A lone requester always wins; on a tie the requester that was not
// granted last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic [1:0] gnt
);

    // One-hot grant, with the tie resolved away from the previous winner
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last_grant == REQ_IFU) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between the instruction fetch unit and the
// load/store unit. One transaction is in flight at a time; the response is
// routed back to whichever requester owns it, and a watchdog turns a
// missing memory response into an error response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              lsu_rsp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    // Counter is wide enough to hold TIMEOUT-1 with a spare bit so that
    // saturation can never alias back onto the timeout value.
    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    req_id_t           last_grant;
    req_id_t           owner;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wen;
    logic [DATA_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_wmask;
    logic [CNT_W-1:0]  wdog_cnt;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic [1:0]        gnt;
    logic              accept;
    logic              wdog_expired;

    rr_arb2 u_rr_arb2 (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // Readiness is gated by reset so nothing is accepted while reset is held
    assign accept       = (state == IDLE) && reset && (gnt != 2'b00);
    assign wdog_expired = (wdog_cnt == CNT_LAST);

    assign mem_addr  = lat_addr;
    assign mem_wen   = lat_wen;
    assign mem_wdata = lat_wdata;
    assign mem_wmask = lat_wmask;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a response on the timeout cycle still counts as a response
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_rsp_valid || wdog_expired) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: handshakes, downstream valid and the owner's response strobe
    always_comb begin
        ifu_req_ready = accept && gnt[0];
        lsu_req_ready = accept && gnt[1];
        mem_req_valid = (state == REQ);
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data  = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_data  = '0;
        lsu_rsp_err   = 1'b0;
        if (state == RESP) begin
            if (owner == REQ_IFU) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_data  = rsp_data;
                ifu_rsp_err   = rsp_err;
            end else begin
                lsu_rsp_valid = 1'b1;
                lsu_rsp_data  = rsp_data;
                lsu_rsp_err   = rsp_err;
            end
        end
    end

    // Request latching, ownership tracking, watchdog and response capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_IFU;
            owner      <= REQ_IFU;
            lat_addr   <= '0;
            lat_wen    <= 1'b0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            wdog_cnt   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (gnt[1]) begin
                            owner      <= REQ_LSU;
                            last_grant <= REQ_LSU;
                            lat_addr   <= lsu_addr;
                            lat_wen    <= lsu_wen;
                            lat_wdata  <= lsu_wdata;
                            lat_wmask  <= lsu_wmask;
                        end else begin
                            owner      <= REQ_IFU;
                            last_grant <= REQ_IFU;
                            lat_addr   <= ifu_addr;
                            lat_wen    <= 1'b0;
                            lat_wdata  <= '0;
                            lat_wmask  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        wdog_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_data <= lat_wen ? '0 : mem_rsp_data;
                        rsp_err  <= 1'b0;
                    end else if (wdog_expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                    if (wdog_cnt != '1) begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of complete transactions
// with hand-computed grants and responses, plus hand-written sequences for
// reset, stray responses and reset in the middle of a transaction.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_rsp_valid;
    logic [DATA_W-1:0] ifu_rsp_data;
    logic              ifu_rsp_err;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wmask;
    logic              lsu_rsp_valid;
    logic [DATA_W-1:0] lsu_rsp_data;
    logic              lsu_rsp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    int total;
    int bad;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_a;
        logic [31:0] lsu_a;
        logic        lsu_w;
        logic [31:0] lsu_d;
        logic [3:0]  lsu_m;
        int          ready_delay;
        int          rsp_at;
        logic [31:0] mem_d;
        logic        exp_lsu;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=stalled exp=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Runs one complete transaction starting at a negedge in IDLE and
    // returns at the negedge where the arbiter is back in IDLE.
    task automatic applyStimulus(input int idx, input vec_t v);
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_wen;
        logic [3:0]  e_mask;
        int          lat;
        bit          seen;

        e_addr  = v.exp_lsu ? v.lsu_a : v.ifu_a;
        e_wen   = v.exp_lsu ? v.lsu_w : 1'b0;
        e_wdata = v.exp_lsu ? v.lsu_d : 32'h0;
        e_mask  = v.exp_lsu ? v.lsu_m : 4'h0;

        ifu_req_valid = v.ifu_v;
        ifu_addr      = v.ifu_a;
        lsu_req_valid = v.lsu_v;
        lsu_addr      = v.lsu_a;
        lsu_wen       = v.lsu_w;
        lsu_wdata     = v.lsu_d;
        lsu_wmask     = v.lsu_m;
        #1;
        checkOutput($sformatf("v%0d ifu_req_ready", idx), ifu_req_ready, !v.exp_lsu);
        checkOutput($sformatf("v%0d lsu_req_ready", idx), lsu_req_ready, v.exp_lsu);
        @(negedge clk);

        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        ifu_addr      = 32'hFFFF_FFF0;
        lsu_addr      = 32'hFFFF_FFF4;
        lsu_wen       = ~v.lsu_w;
        lsu_wdata     = 32'h0BAD_F00D;
        lsu_wmask     = 4'b1010;
        for (int k = 0; k <= v.ready_delay; k++) begin
            checkOutput($sformatf("v%0d c%0d mem_req_valid", idx, k), mem_req_valid, 1'b1);
            checkOutput($sformatf("v%0d c%0d mem_addr", idx, k), mem_addr, e_addr);
            checkOutput($sformatf("v%0d c%0d mem_wen", idx, k), mem_wen, e_wen);
            checkOutput($sformatf("v%0d c%0d mem_wdata", idx, k), mem_wdata, e_wdata);
            checkOutput($sformatf("v%0d c%0d mem_wmask", idx, k), mem_wmask, e_mask);
            mem_req_ready = (k == v.ready_delay);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        checkOutput($sformatf("v%0d mem_req_valid_after_ack", idx), mem_req_valid, 1'b0);

        lat  = 0;
        seen = 0;
        mem_rsp_data = v.mem_d;
        for (int w = 0; w < 12 && !seen; w++) begin
            mem_rsp_valid = (w == v.rsp_at);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                seen = 1;
                lat  = w + 1;
            end
        end
        checkOutput($sformatf("v%0d rsp_latency", idx), lat, v.exp_lat);
        if (seen) begin
            checkOutput($sformatf("v%0d ifu_rsp_valid", idx), ifu_rsp_valid, !v.exp_lsu);
            checkOutput($sformatf("v%0d lsu_rsp_valid", idx), lsu_rsp_valid, v.exp_lsu);
            checkOutput($sformatf("v%0d rsp_data", idx),
                        v.exp_lsu ? lsu_rsp_data : ifu_rsp_data, v.exp_data);
            checkOutput($sformatf("v%0d rsp_err", idx),
                        v.exp_lsu ? lsu_rsp_err : ifu_rsp_err, v.exp_err);
            checkOutput($sformatf("v%0d other_rsp_data", idx),
                        v.exp_lsu ? ifu_rsp_data : lsu_rsp_data, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("v%0d rsp_one_cycle", idx),
                        {31'h0, ifu_rsp_valid | lsu_rsp_valid}, 32'h0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //           ifu lsu ifu_a         lsu_a         w  lsu_d         m     rdy at  mem_d         lsu data          err lat
        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0,         4'h0, 0, 0,  32'h0010_0093, 1'b0, 32'h0010_0093, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0100, 32'h8000_2000, 1'b0, 32'h0,         4'hF, 0, 0,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_2004, 1'b0, 32'h0,         4'hF, 0, 0,  32'h0020_0113, 1'b0, 32'h0020_0113, 1'b0, 1};
        vecs[3] = '{1'b1, 1'b1, 32'h8000_0008, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 3, 1,  32'h5555_5555, 1'b1, 32'h0,         1'b0, 2};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0,         1'b0, 32'h0,         4'h0, 1, 3,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 4};
        vecs[5] = '{1'b0, 1'b1, 32'h0,         32'h8000_2008, 1'b0, 32'h1111_1111, 4'hF, 0, 2,  32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b0, 3};
        vecs[6] = '{1'b0, 1'b1, 32'h0,         32'h8000_2010, 1'b0, 32'h0,         4'hF, 0, -1, 32'h7777_7777, 1'b1, 32'h0,         1'b1, 4};

        reset         = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hFFFF_FFFF;
        lsu_wmask     = 4'hF;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        repeat (2) @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("rst ifu_req_ready", ifu_req_ready, 1'b0);
        checkOutput("rst lsu_req_ready", lsu_req_ready, 1'b0);
        checkOutput("rst mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        checkOutput("rst mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst mem_wmask", mem_wmask, 4'h0);
        checkOutput("rst rsp_valid", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);

        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clk);

        $display("[TB] running transaction table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] stray responses in IDLE");
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stray%0d rsp_valid", k), {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
            checkOutput($sformatf("stray%0d mem_req_valid", k), mem_req_valid, 1'b0);
        end
        mem_rsp_valid = 1'b0;

        $display("[TB] reset during REQ");
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        checkOutput("rreq mem_req_valid_before", mem_req_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rreq mem_req_valid_async", mem_req_valid, 1'b0);
        checkOutput("rreq mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] reset during WAIT");
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_3000;
        lsu_wen       = 1'b0;
        #1;
        checkOutput("rwait lsu_req_ready", lsu_req_ready, 1'b1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rwait mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("rwait mem_addr", mem_addr, 32'h0);
        checkOutput("rwait ready", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h0);
        checkOutput("rwait rsp_valid", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_0001;
        @(negedge clk);
        checkOutput("rwait held ready", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h0);
        checkOutput("rwait late rsp", {30'h0, ifu_rsp_valid, lsu_rsp_valid}, 32'h0);
        mem_rsp_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rwait tie ifu_req_ready", ifu_req_ready, 1'b0);
        checkOutput("rwait tie lsu_req_ready", lsu_req_ready, 1'b1);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rwait no accept", mem_req_valid, 1'b0);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
